// File: rtl/chorus_ctrl.sv
// chorus_ctrl: sequencer for a chorus effect built around an external delay
// buffer. Each input sample is written to the buffer, and a sample from an
// earlier position is read back. How far back it reads is set by a triangle
// LFO. The delay is AVG_DELAY plus an offset that the LFO modulates.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   sample_valid_i/sample_i new input sample (one-cycle pulse)
//   freqSetting_i           LFO phase increment per sample
//   scaleFactor_i           LFO depth (0 = no modulation)
//   wr_en_o/wr_addr_o/wr_data_o  delay-buffer write port
//   rd_en_o/rd_addr_o/rd_data_i  delay-buffer read port (data one cycle after rd_en_o)
//   sample_o/sample_valid_o delayed output sample and its qualifier pulse
//   error_o                 sticky overrun flag (sample arrived while busy)
module chorus_ctrl #(
  parameter int unsigned PKT_WIDTH = 16,
  parameter int unsigned BUF_DEPTH = 90,
  parameter int unsigned AVG_DELAY = 2,
  localparam int unsigned AW = $clog2(BUF_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sample_valid_i,
  input  logic [PKT_WIDTH-1:0] sample_i,
  input  logic [3:0]           freqSetting_i,
  input  logic [3:0]           scaleFactor_i,
  output logic                 wr_en_o,
  output logic [AW-1:0]        wr_addr_o,
  output logic [PKT_WIDTH-1:0] wr_data_o,
  output logic                 rd_en_o,
  output logic [AW-1:0]        rd_addr_o,
  input  logic [PKT_WIDTH-1:0] rd_data_i,
  output logic [PKT_WIDTH-1:0] sample_o,
  output logic                 sample_valid_o,
  output logic                 error_o
);

  localparam int unsigned FW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [FW-1:0]        fill_cnt_q;
  logic [11:0]          lfo_acc_q;
  logic [3:0]           freq_q;
  logic [3:0]           scale_q;
  logic                 error_q;
  logic                 wr_en_q;
  logic [AW-1:0]        wr_addr_q;
  logic [PKT_WIDTH-1:0] wr_data_q;
  logic                 rd_en_q;
  logic [AW-1:0]        rd_addr_q;
  logic [PKT_WIDTH-1:0] sample_q;
  logic                 sample_valid_q;

  // Delay derivation. It uses lfo_acc_q as it stands before the OUT update.
  logic [10:0]   tri_val;
  logic [14:0]   mod_prod;
  logic [3:0]    offset;
  logic [31:0]   delay_sum;
  logic [AW-1:0] delay_w;
  logic [AW-1:0] rd_addr_d;
  logic          gate_zero;

  always_comb begin
    tri_val   = lfo_acc_q[11] ? ~lfo_acc_q[10:0] : lfo_acc_q[10:0];
    mod_prod  = 15'(tri_val) * 15'(scale_q);
    offset    = mod_prod[14:11];
    delay_sum = AVG_DELAY + 32'(offset);
    delay_w   = (delay_sum > BUF_DEPTH - 1) ? AW'(BUF_DEPTH - 1) : AW'(delay_sum);
    if (wr_ptr_q < delay_w) begin
      rd_addr_d = AW'(32'(wr_ptr_q) + BUF_DEPTH - 32'(delay_w));
    end else begin
      rd_addr_d = wr_ptr_q - delay_w;
    end
    // Positions not yet written since reset read back as silence.
    gate_zero = 32'(delay_w) > 32'(fill_cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      fill_cnt_q     <= '0;
      lfo_acc_q      <= '0;
      freq_q         <= '0;
      scale_q        <= '0;
      error_q        <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      if (sample_valid_i && (state_q != ST_IDLE)) begin
        error_q <= 1'b1;
      end
      // Strobes are set on the edge that enters a state, so each one is
      // high for exactly that state's cycle.
      case (state_q)
        ST_IDLE: begin
          if (sample_valid_i) begin
            freq_q    <= freqSetting_i;
            scale_q   <= scaleFactor_i;
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_ptr_q;
            wr_data_q <= sample_i;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= rd_addr_d;
          state_q   <= ST_READ;
        end
        ST_READ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          sample_q       <= gate_zero ? '0 : rd_data_i;
          sample_valid_q <= 1'b1;
          state_q        <= ST_OUT;
        end
        ST_OUT: begin
          wr_ptr_q <= (wr_ptr_q == AW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
          if (fill_cnt_q != FW'(BUF_DEPTH)) begin
            fill_cnt_q <= fill_cnt_q + FW'(1);
          end
          lfo_acc_q <= lfo_acc_q + 12'(freq_q);
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign rd_en_o        = rd_en_q;
  assign rd_addr_o      = rd_addr_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_chorus_ctrl.sv
// Testbench for chorus_ctrl: random and directed sample streams. The expected
// behaviour comes from a sample-history model and is checked by a monitor
// that works from a scoreboard queue.
module tb_chorus_ctrl;

  localparam int PW    = 16;
  localparam int DEPTH = 90;
  localparam int AVG   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          sample_valid_i = 1'b0;
  logic [PW-1:0] sample_i = '0;
  logic [3:0]    freqSetting_i = '0;
  logic [3:0]    scaleFactor_i = '0;
  logic          wr_en_o, rd_en_o, sample_valid_o, error_o;
  logic [AW-1:0] wr_addr_o, rd_addr_o;
  logic [PW-1:0] wr_data_o, sample_o;
  logic [PW-1:0] rd_data_i = '0;

  chorus_ctrl #(.PKT_WIDTH(PW), .BUF_DEPTH(DEPTH), .AVG_DELAY(AVG)) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_valid_i(sample_valid_i), .sample_i(sample_i),
    .freqSetting_i(freqSetting_i), .scaleFactor_i(scaleFactor_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External delay buffer. Its initial contents are junk so that missing
  // fill gating shows up as wrong output data.
  logic [PW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 16'hBEEF;
  always @(posedge clk) begin
    if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  typedef struct {
    int          wa;
    int          ra;
    logic [PW-1:0] din;
    logic [PW-1:0] dout;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state: every sample since reset, plus the LFO phase.
  logic [PW-1:0] hist[$];
  int  lfo = 0;
  int  last_acc = -100;
  bit  err_exp = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  function automatic void model_reset();
    hist.delete();
    exp_q.delete();
    lfo = 0;
    last_acc = -100;
    err_exp = 1'b0;
  endfunction

  // Called in the cycle the input is presented.
  function automatic void model_sample(input logic [PW-1:0] s, input int f, input int sc);
    int n, tv, d;
    exp_t e;
    if (cyc - last_acc < 5) begin
      err_exp = 1'b1;
      return;
    end
    last_acc = cyc;
    n  = hist.size();
    tv = (lfo >= 2048) ? 4095 - lfo : lfo;
    d  = AVG + (tv * sc) / 2048;
    if (d > DEPTH - 1) d = DEPTH - 1;
    e.wa   = n % DEPTH;
    e.ra   = (((n - d) % DEPTH) + DEPTH) % DEPTH;
    e.din  = s;
    e.dout = (d > n) ? '0 : hist[n - d];
    e.due  = cyc + 4;
    exp_q.push_back(e);
    hist.push_back(s);
    lfo = (lfo + f) % 4096;
  endfunction

  // Monitor.
  always @(negedge clk) begin
    int act;
    act = int'(wr_en_o) + int'(rd_en_o) + int'(sample_valid_o);
    if (act != 0) check(act == 1, "strobe_exclusive", act, 1);
    if (!rst_i) check(error_o == err_exp, "error_o", error_o, err_exp);
    if (wr_en_o) begin
      if (exp_q.size() == 0) check(1'b0, "unexpected_write", 1, 0);
      else begin
        check(wr_addr_o == exp_q[0].wa, "wr_addr", wr_addr_o, exp_q[0].wa);
        check(wr_data_o == exp_q[0].din, "wr_data", wr_data_o, exp_q[0].din);
      end
    end
    if (rd_en_o) begin
      if (exp_q.size() == 0) check(1'b0, "unexpected_read", 1, 0);
      else check(rd_addr_o == exp_q[0].ra, "rd_addr", rd_addr_o, exp_q[0].ra);
    end
    if (sample_valid_o) begin
      if (exp_q.size() == 0) check(1'b0, "unexpected_out", 1, 0);
      else begin
        check(sample_o == exp_q[0].dout, "sample_o", sample_o, exp_q[0].dout);
        check(cyc == exp_q[0].due, "out_latency", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
      check(1'b0, "missing_out", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  // All driver tasks start and end just after a falling edge.
  task automatic idle(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic send(input logic [PW-1:0] s, input int f, input int sc);
    sample_i = s;
    freqSetting_i = 4'(f);
    scaleFactor_i = 4'(sc);
    sample_valid_i = 1'b1;
    model_sample(s, f, sc);
    idle(1);
    sample_valid_i = 1'b0;
  endtask

  task automatic do_reset(input bit with_valid);
    rst_i = 1'b1;
    sample_valid_i = with_valid;
    model_reset();
    @(negedge clk);
    check({wr_en_o, rd_en_o, sample_valid_o, error_o, wr_addr_o, rd_addr_o, wr_data_o, sample_o} == '0,
          "reset_outputs", {wr_en_o, rd_en_o, sample_valid_o, error_o, wr_addr_o, rd_addr_o, wr_data_o, sample_o}, 0);
    #1;
    rst_i = 1'b0;
    sample_valid_i = 1'b0;
  endtask

  task automatic drain();
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin idle(1); budget--; end
    if (exp_q.size() != 0) check(1'b0, "drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    @(negedge clk); #1;
    do_reset(1'b1);

    // Warm-up: 0x0001..0x0005, ten cycles apart.
    for (int k = 1; k <= 5; k++) begin send(PW'(k), 0, 0); idle(9); end
    drain();

    // Wrap: 92 samples at full throughput.
    do_reset(1'b0);
    for (int k = 1; k <= 92; k++) begin send(PW'(k), 0, 0); idle(4); end
    drain();

    // Overrun: second pulse two cycles after the first.
    do_reset(1'b0);
    send(16'h1111, 0, 0);
    idle(1);
    send(16'h2222, 0, 0);
    idle(6);
    send(16'h3333, 0, 0);
    drain();

    // Reset while in WAIT, then the next sample starts from scratch.
    send(16'h4444, 0, 0);
    idle(2);
    do_reset(1'b0);
    send(16'h5555, 0, 0);
    drain();

    // Modulation: freq=1, scale=15, long enough to pass lfo_acc=1024.
    do_reset(1'b0);
    for (int k = 0; k < 1100; k++) begin send(PW'($urandom), 1, 15); idle(4); end
    drain();

    // Random traffic with occasional overruns and resets.
    do_reset(1'b0);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom_range(0, 1)));
      send(PW'($urandom), $urandom_range(0, 15), $urandom_range(0, 15));
      idle($urandom_range(0, 6));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
